mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  fetch-port request; held high until i_gnt.
REQ-006 i_addr  input  ADDR_W  fetch address, valid while i_req.
REQ-007 i_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-008 i_rvalid  output  1  one-cycle pulse: i_rdata valid.
REQ-009 i_rdata  output  DATA_W  fetched instruction word.
REQ-010 d_req  input  1  data-port request; held high until d_gnt.
REQ-011 d_we  input  1  data-port write enable, valid while d_req.
REQ-012 d_addr  input  ADDR_W  data address, valid while d_req.
REQ-013 d_wdata  input  DATA_W  store data, valid while d_req.
REQ-014 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-015 d_rvalid  output  1  one-cycle pulse: load data valid or store complete.
REQ-016 d_rdata  output  DATA_W  load data; 0 for stores.
REQ-017 mem_req  output  1  request to the shared memory; held until mem_ack.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_addr  output  ADDR_W  memory address.
REQ-020 mem_wdata  output  DATA_W  memory write data.
REQ-021 mem_ack  input  1  memory completion; sampled only while mem_req is high.
REQ-022 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
REQ-023 owner  output  1  0 = fetch, 1 = data; the owner of the current or last transaction.

Function
REQ-024 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-025 IDLE with any request: at the edge, latch the winner's address, data and write enable into the mem_* registers, pulse the winner's gnt, set mem_req, set owner and go to BUSY.
REQ-026 IDLE with no request: remain in IDLE and keep mem_req low.
REQ-027 BUSY: hold mem_req and all mem_* outputs stable until the edge where mem_ack=1, then capture mem_rdata, drop mem_req and go to RESP.
REQ-028 BUSY with mem_ack low: remain in BUSY indefinitely; there is no timeout.
REQ-029 RESP: pulse the owner's rvalid for exactly one cycle and drive its rdata, then go to IDLE; no grant is issued while in RESP.
REQ-030 Minimum latency: request in cycle N, gnt and mem_req in N+1, mem_ack in N+1, rvalid in N+2.
REQ-031 Maximum throughput: one transaction per 3 cycles.
REQ-032 i_rdata and d_rdata SHALL hold their last captured value; d_rdata is cleared to 0 on a store response.
REQ-033 Requests arriving while in BUSY or RESP SHALL wait; they are never dropped or reordered.
REQ-034 mem_ack while in IDLE or RESP SHALL be ignored.
REQ-035 i_gnt and d_gnt SHALL never be high in the same cycle; the same holds for i_rvalid and d_rvalid.

Reset
REQ-036 Reset low SHALL immediately force IDLE, clear every output and the round-robin pointer, and abort any in-flight transaction with no rvalid.
REQ-037 Requests held high through reset SHALL first be considered at the first edge after reset deasserts.

Configuration
REQ-038 Without MEM_ARB_RR_EN: fixed priority, with data beating fetch on simultaneous requests.
REQ-039 With MEM_ARB_RR_EN: on simultaneous requests, grant the port that was not granted last; after reset the data port wins the first tie.

Structure
REQ-040 Package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY/RESP) and the owner encoding constants OWN_FETCH=0 and OWN_DATA=1.
REQ-041 The winner selection SHALL live in one combinational sub-module, arb_pick, with inputs i_req, d_req and last_owner, and output win.

Verification
REQ-042 Fetch only: i_req, i_addr=0x100, mem_ack on the first BUSY cycle with mem_rdata=0x00500093 -> i_gnt in N+1, mem_addr=0x100, mem_we=0, i_rvalid in N+2, i_rdata=0x00500093.
REQ-043 Store: d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, 3-cycle ack delay -> mem_req high 3 cycles with stable address and data, then d_rvalid, d_rdata=0.
REQ-044 Simultaneous i_req and d_req, held for two transactions -> fixed priority: d, then i; MEM_ARB_RR_EN: d, then i, then d on the next tie.
REQ-045 Reset asserted in BUSY -> mem_req low immediately, no rvalid; after release a pending i_req receives i_gnt on the first edge.
REQ-046 mem_ack pulsed while in IDLE and in RESP -> no state change, no rvalid.
REQ-047 d_req asserted in RESP of a fetch -> d_gnt exactly one cycle after the return to IDLE, with no extra fetch grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and owner encoding for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory handshake bundle for mem_arbiter
//   fetch port : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   data port  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   memory port: mem_req, mem_we, mem_addr, mem_wdata <- mem_ack, mem_rdata
//   owner      : 0 = fetch, 1 = data, current or last transaction
//   modport slave is the arbiter side, modport master the requester/memory side
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, owner
    );

endinterface

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select between fetch and data requests
//   i_req, d_req : pending requests
//   last_owner   : owner of the previous transaction
//   win          : selected port (OWN_FETCH / OWN_DATA)
//   MEM_ARB_RR_EN: defined -> alternate on ties; undefined -> data beats fetch
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic win
);

    always_comb begin
        // With no request the value is irrelevant; hold the last owner.
        win = last_owner;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            // Pointer resets to fetch, so data wins the first tie.
            win = ~last_owner;
`else
            win = OWN_DATA;
`endif
        end else if (d_req) begin
            win = OWN_DATA;
        end else if (i_req) begin
            win = OWN_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (fetch, data and memory handshakes, owner)
//   MEM_ARB_RR_EN: enables alternating tie-break in arb_pick
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    state_t            state;
    logic              owner_q;
    logic              win;

    logic              i_gnt_q;
    logic              d_gnt_q;
    logic              i_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // owner_q doubles as the round-robin pointer.
    arb_pick u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_owner (owner_q),
        .win        (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner_q     <= OWN_FETCH;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Grants and rvalids are single-cycle pulses.
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        owner_q   <= win;
                        mem_req_q <= 1'b1;
                        state     <= BUSY;
                        if (win == OWN_DATA) begin
                            d_gnt_q     <= 1'b1;
                            mem_we_q    <= bus.d_we;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                        end else begin
                            i_gnt_q     <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.i_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= RESP;
                        if (owner_q == OWN_DATA) begin
                            d_rvalid_q <= 1'b1;
                            // Store responses carry no data.
                            d_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
                        end else begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= bus.mem_rdata;
                        end
                    end
                end
                RESP: begin
                    // Turnaround cycle: rvalid is visible, no new grant.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_gnt     = i_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic w2;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("gnt_excl", {63'd0, bus.i_gnt & bus.d_gnt}, 64'd0);
            check("rvalid_excl", {63'd0, bus.i_rvalid & bus.d_rvalid}, 64'd0);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
`ifdef MEM_ARB_RR_EN
        w2 = 1'b0;
`else
        w2 = 1'b1;
`endif
        reset         = 1'b0;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        step();
        step();

        // reset state
        check("rst_i_gnt", bus.i_gnt, 0);
        check("rst_d_gnt", bus.d_gnt, 0);
        check("rst_i_rvalid", bus.i_rvalid, 0);
        check("rst_d_rvalid", bus.d_rvalid, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_i_rdata", bus.i_rdata, 0);

        // fetch only, minimum latency
        reset = 1'b1;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        #3 check("f_pre_gnt", bus.i_gnt, 0);
        step();
        check("f_gnt", bus.i_gnt, 1);
        check("f_d_gnt", bus.d_gnt, 0);
        check("f_mem_req", bus.mem_req, 1);
        check("f_mem_addr", bus.mem_addr, 32'h100);
        check("f_mem_we", bus.mem_we, 0);
        check("f_owner", bus.owner, 0);
        bus.i_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00500093;
        step();
        check("f_rvalid", bus.i_rvalid, 1);
        check("f_rdata", bus.i_rdata, 32'h00500093);
        check("f_mem_req_drop", bus.mem_req, 0);
        check("f_gnt_pulse", bus.i_gnt, 0);
        bus.mem_ack = 1'b0;
        step();
        check("f_rvalid_pulse", bus.i_rvalid, 0);

        // data load, preloads d_rdata
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h40;
        step();
        check("ld_gnt", bus.d_gnt, 1);
        check("ld_owner", bus.owner, 1);
        bus.d_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        step();
        check("ld_rvalid", bus.d_rvalid, 1);
        check("ld_rdata", bus.d_rdata, 32'h12345678);
        bus.mem_ack = 1'b0;
        step();

        // store with 3-cycle ack delay
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.d_wdata = 32'hDEADBEEF;
        step();
        check("st_gnt", bus.d_gnt, 1);
        check("st_mem_we", bus.mem_we, 1);
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            check("st_mem_req", bus.mem_req, 1);
            check("st_mem_addr", bus.mem_addr, 32'h2000);
            check("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
            check("st_no_rvalid", bus.d_rvalid, 0);
            if (k == 2) bus.mem_ack = 1'b1;
            step();
        end
        check("st_rvalid", bus.d_rvalid, 1);
        check("st_rdata_zero", bus.d_rdata, 0);
        check("st_mem_req_drop", bus.mem_req, 0);
        check("st_i_rdata_hold", bus.i_rdata, 32'h00500093);
        bus.mem_ack = 1'b0;
        step();
        check("st_d_rdata_hold", bus.d_rdata, 0);

        // mem_ack in IDLE is ignored
        bus.mem_ack = 1'b1;
        step();
        check("ia_mem_req", bus.mem_req, 0);
        check("ia_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
        step();
        check("ia_rvalid2", {bus.i_rvalid, bus.d_rvalid}, 0);
        bus.mem_ack = 1'b0;

        // fetch; mem_ack held and d_req raised during RESP
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h104;
        step();
        check("ra_i_gnt", bus.i_gnt, 1);
        bus.i_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h11111111;
        step();
        check("ra_i_rvalid", bus.i_rvalid, 1);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h600;
        step();
        check("ra_no_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
        check("ra_no_gnt", {bus.i_gnt, bus.d_gnt}, 0);
        check("ra_mem_req", bus.mem_req, 0);
        check("ra_i_rdata", bus.i_rdata, 32'h11111111);
        bus.mem_ack = 1'b0;
        step();
        check("ra_d_gnt", bus.d_gnt, 1);
        check("ra_no_i_gnt", bus.i_gnt, 0);
        check("ra_mem_addr", bus.mem_addr, 32'h600);
        bus.d_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h22222222;
        step();
        check("ra_d_rvalid", bus.d_rvalid, 1);
        check("ra_d_rdata", bus.d_rdata, 32'h22222222);
        bus.mem_ack = 1'b0;
        step();

        // reset asserted in BUSY
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h500;
        step();
        check("rb_gnt", bus.i_gnt, 1);
        step();
        check("rb_busy", bus.mem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("rb_mem_req_async", bus.mem_req, 0);
        check("rb_mem_addr_async", bus.mem_addr, 0);
        check("rb_i_rdata_clr", bus.i_rdata, 0);
        step();
        check("rb_no_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
        check("rb_no_gnt", bus.i_gnt, 0);
        reset = 1'b1;
        step();
        check("rb_regrant", bus.i_gnt, 1);
        check("rb_mem_addr", bus.mem_addr, 32'h500);
        bus.i_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h33333333;
        step();
        check("rb_rvalid", bus.i_rvalid, 1);
        bus.mem_ack = 1'b0;
        step();

        // simultaneous requests from a fresh reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h300;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h400;
        step();
        check("t1_d_gnt", bus.d_gnt, 1);
        check("t1_i_gnt", bus.i_gnt, 0);
        check("t1_addr", bus.mem_addr, 32'h400);
        bus.d_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hAAAA0001;
        step();
        check("t1_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b01);
        check("t1_rdata", bus.d_rdata, 32'hAAAA0001);
        bus.mem_ack = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h404;
        step();
        check("t_resp_no_gnt", {bus.i_gnt, bus.d_gnt}, 0);
        step();
        check("t2_owner", bus.owner, w2);
        check("t2_gnt", {bus.i_gnt, bus.d_gnt}, w2 ? 2'b01 : 2'b10);
        check("t2_addr", bus.mem_addr, w2 ? 32'h404 : 32'h300);
        if (w2) bus.d_req = 1'b0;
        else    bus.i_req = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBBBB0002;
        step();
        check("t2_rvalid", {bus.i_rvalid, bus.d_rvalid}, w2 ? 2'b01 : 2'b10);
        bus.mem_ack = 1'b0;
        step();
        step();
        check("t3_owner", bus.owner, !w2);
        check("t3_gnt", {bus.i_gnt, bus.d_gnt}, w2 ? 2'b10 : 2'b01);
        check("t3_addr", bus.mem_addr, w2 ? 32'h300 : 32'h404);
        bus.i_req     = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCCCC0003;
        step();
        check("t3_rvalid", {bus.i_rvalid, bus.d_rvalid}, w2 ? 2'b10 : 2'b01);
        bus.mem_ack = 1'b0;
        step();
        check("end_idle", bus.mem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
